// File: rtl/trng_flow_ctrl_pkg.sv
// Shared definitions for the TRNG flow controller: FSM state encodings and helpers.
package trng_flow_ctrl_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_WARMUP  = 3'd1,
        ST_DISCARD = 3'd2,
        ST_RUN     = 3'd3,
        ST_PAUSE   = 3'd4,
        ST_FAULT   = 3'd5
    } state_t;

    // The TRNG core is powered only while we intend to consume its output.
    function automatic logic gen_active(input state_t s);
        return (s == ST_WARMUP) || (s == ST_DISCARD) || (s == ST_RUN);
    endfunction

endpackage

// File: rtl/trng_rep_check.sv
// Repetition-count health test: flags a word that would make REP_LIMIT identical words in a row.
module trng_rep_check #(
    parameter int W         = 32,
    parameter int REP_LIMIT = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         valid,
    input  logic [W-1:0] word,
    output logic         rep_fail
);

    localparam int CNT_W = $clog2(REP_LIMIT + 1);

    logic [W-1:0]     last_word_q;
    logic             have_q;
    logic [CNT_W-1:0] rep_cnt_q;
    logic             same;

    assign same     = have_q && (word == last_word_q);
    assign rep_fail = valid && same && (rep_cnt_q == CNT_W'(REP_LIMIT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_word_q <= '0;
            have_q      <= 1'b0;
            rep_cnt_q   <= '0;
        end else if (clear) begin
            have_q    <= 1'b0;
            rep_cnt_q <= '0;
        end else if (valid) begin
            last_word_q <= word;
            have_q      <= 1'b1;
            if (!same)
                rep_cnt_q <= CNT_W'(1);
            else if (rep_cnt_q != CNT_W'(REP_LIMIT))
                rep_cnt_q <= rep_cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/trng_flow_ctrl.sv
// Sequences the TRNG core into the CPU FIFO: warm-up, post-start discard, FIFO-level
// hysteresis, repetition health test, write gating and word/drop statistics.
module trng_flow_ctrl
    import trng_flow_ctrl_pkg::*;
#(
    parameter int WARMUP_CYCLES = 1024,
    parameter int DISCARD_WORDS = 4,
    parameter int LEVEL_W       = 5,
    parameter int HI_WM         = 14,
    parameter int LO_WM         = 4,
    parameter int REP_LIMIT     = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               host_enable,
    input  logic               fault_clr,
    input  logic [31:0]        trng_word,
    input  logic               trng_valid,
    input  logic [LEVEL_W-1:0] fifo_level,
    input  logic               fifo_full,
    output logic               trng_enable,
    output logic               wr_en,
    output logic [31:0]        wr_data,
    output logic [STATE_W-1:0] state_out,
    output logic               fault,
    output logic [31:0]        word_count,
    output logic [15:0]        drop_count
);

    localparam int WARM_W = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
    localparam int DISC_W = (DISCARD_WORDS > 1) ? $clog2(DISCARD_WORDS + 1) : 1;
    localparam logic [LEVEL_W-1:0] HI_L = LEVEL_W'(HI_WM);
    localparam logic [LEVEL_W-1:0] LO_L = LEVEL_W'(LO_WM);
    // With no discard configured, a (re)start drops straight into RUN.
    localparam state_t RESUME_ST = (DISCARD_WORDS == 0) ? ST_RUN : ST_DISCARD;

    state_t              state_q, state_d;
    logic                trng_enable_q;
    logic                fault_q;
    logic [WARM_W-1:0]   warm_cnt_q;
    logic [DISC_W-1:0]   disc_cnt_q;
    logic [31:0]         word_count_q;
    logic [15:0]         drop_count_q;

    logic health_active;
    logic rep_fail;
    logic warm_done;
    logic drop_inc;

    assign health_active = (state_q == ST_DISCARD) || (state_q == ST_RUN);
    assign warm_done     = (WARMUP_CYCLES <= 1) || (warm_cnt_q == WARM_W'(WARMUP_CYCLES - 1));

    trng_rep_check #(
        .W         (32),
        .REP_LIMIT (REP_LIMIT)
    ) u_rep_check (
        .clk      (clk),
        .rst      (rst),
        .clear    (!health_active),
        .valid    (trng_valid && health_active),
        .word     (trng_word),
        .rep_fail (rep_fail)
    );

    assign wr_en    = (state_q == ST_RUN) && trng_valid && !fifo_full && !rep_fail;
    assign wr_data  = trng_word;
    assign drop_inc = trng_valid && (((state_q == ST_RUN) && fifo_full) || (state_q == ST_PAUSE));

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:
                if (host_enable) state_d = ST_WARMUP;
            ST_WARMUP:
                if (!host_enable)   state_d = ST_IDLE;
                else if (warm_done) state_d = RESUME_ST;
            ST_DISCARD:
                if (rep_fail)          state_d = ST_FAULT;
                else if (!host_enable) state_d = ST_IDLE;
                else if (trng_valid && (disc_cnt_q == DISC_W'(1)))
                    state_d = ST_RUN;
            ST_RUN:
                if (rep_fail)                state_d = ST_FAULT;
                else if (!host_enable)       state_d = ST_IDLE;
                else if (fifo_level >= HI_L) state_d = ST_PAUSE;
            ST_PAUSE:
                if (!host_enable)            state_d = ST_IDLE;
                else if (fifo_level <= LO_L) state_d = RESUME_ST;
            ST_FAULT:
                if (fault_clr) state_d = ST_IDLE;
            default:
                state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            trng_enable_q <= 1'b0;
            fault_q       <= 1'b0;
            warm_cnt_q    <= '0;
            disc_cnt_q    <= '0;
            word_count_q  <= '0;
            drop_count_q  <= '0;
        end else begin
            state_q       <= state_d;
            trng_enable_q <= gen_active(state_d);
            fault_q       <= (state_d == ST_FAULT);

            if (state_q != ST_WARMUP)
                warm_cnt_q <= '0;
            else if (!warm_done)
                warm_cnt_q <= warm_cnt_q + WARM_W'(1);

            if ((state_d == ST_DISCARD) && (state_q != ST_DISCARD))
                disc_cnt_q <= DISC_W'(DISCARD_WORDS);
            else if ((state_q == ST_DISCARD) && trng_valid && (disc_cnt_q != '0))
                disc_cnt_q <= disc_cnt_q - DISC_W'(1);

            if (wr_en)
                word_count_q <= word_count_q + 32'd1;

            if (drop_inc && (drop_count_q != 16'hFFFF))
                drop_count_q <= drop_count_q + 16'd1;
        end
    end

    assign trng_enable = trng_enable_q;
    assign fault       = fault_q;
    assign state_out   = state_q;
    assign word_count  = word_count_q;
    assign drop_count  = drop_count_q;

endmodule

// File: tb/tb_trng_flow_ctrl.sv
// Directed bench for trng_flow_ctrl: expected FIFO writes go into a scoreboard queue
// that an independent negedge monitor drains; status outputs are checked against constants.
module tb_trng_flow_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        host_enable = 1'b0;
    logic        fault_clr = 1'b0;
    logic [31:0] trng_word = '0;
    logic        trng_valid = 1'b0;
    logic [4:0]  fifo_level = '0;
    logic        fifo_full = 1'b0;
    logic        trng_enable;
    logic        wr_en;
    logic [31:0] wr_data;
    logic [2:0]  state_out;
    logic        fault;
    logic [31:0] word_count;
    logic [15:0] drop_count;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    trng_flow_ctrl #(
        .WARMUP_CYCLES (8),
        .DISCARD_WORDS (2),
        .LEVEL_W       (5),
        .HI_WM         (14),
        .LO_WM         (4),
        .REP_LIMIT     (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .host_enable (host_enable),
        .fault_clr   (fault_clr),
        .trng_word   (trng_word),
        .trng_valid  (trng_valid),
        .fifo_level  (fifo_level),
        .fifo_full   (fifo_full),
        .trng_enable (trng_enable),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .state_out   (state_out),
        .fault       (fault),
        .word_count  (word_count),
        .drop_count  (drop_count)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: every write the DUT presents must match the oldest expected word.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL wr_unexpected: got write of %h, required no write", wr_data);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (wr_data !== e) begin
                    n_err++;
                    $display("FAIL wr_data: got %h, required %h", wr_data, e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [31:0] w, input bit exp_wr);
        trng_word  = w;
        trng_valid = 1'b1;
        if (exp_wr) exp_q.push_back(w);
        step();
        trng_valid = 1'b0;
    endtask

    initial begin
        // Reset state
        step(2);
        check("rst_state", 32'(state_out), 32'd0);
        check("rst_enable", 32'(trng_enable), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_wc", word_count, 32'd0);
        check("rst_drop", 32'(drop_count), 32'd0);
        rst = 1'b0;

        // Start-up: warm-up 8 cycles, two discards, then the first write
        host_enable = 1'b1;
        step();
        check("start_state", 32'(state_out), 32'd1);
        check("start_enable", 32'(trng_enable), 32'd1);
        send(32'h1111_0001, 1'b0);
        step(3);
        send(32'h1111_0002, 1'b0);
        step(3);
        check("warm_done_state", 32'(state_out), 32'd2);
        check("warm_wc", word_count, 32'd0);
        check("warm_drop", 32'(drop_count), 32'd0);
        send(32'h2222_0001, 1'b0);
        step(3);
        send(32'h2222_0002, 1'b0);
        step(3);
        check("disc_done_state", 32'(state_out), 32'd3);
        send(32'hC0DE_0001, 1'b1);
        check("first_wc", word_count, 32'd1);
        check("first_q", 32'(exp_q.size()), 32'd0);

        // Hysteresis
        fifo_level = 5'd13;
        step();
        check("lvl13_state", 32'(state_out), 32'd3);
        fifo_level = 5'd14;
        step();
        check("lvl14_state", 32'(state_out), 32'd4);
        check("lvl14_enable", 32'(trng_enable), 32'd0);
        send(32'h3333_0001, 1'b0);
        check("pause_drop", 32'(drop_count), 32'd1);
        fifo_level = 5'd5;
        step(3);
        check("lvl5_state", 32'(state_out), 32'd4);
        fifo_level = 5'd4;
        step();
        check("lvl4_state", 32'(state_out), 32'd2);
        check("lvl4_enable", 32'(trng_enable), 32'd1);
        send(32'h4444_0001, 1'b0);
        send(32'h4444_0002, 1'b0);
        send(32'hC0DE_0002, 1'b1);
        check("resume_wc", word_count, 32'd2);
        check("resume_drop", 32'(drop_count), 32'd1);

        // FIFO full
        fifo_full  = 1'b1;
        fifo_level = 5'd10;
        send(32'h5555_0001, 1'b0);
        send(32'h5555_0002, 1'b0);
        send(32'h5555_0003, 1'b0);
        check("full_drop", 32'(drop_count), 32'd4);
        check("full_wc", word_count, 32'd2);
        check("full_state", 32'(state_out), 32'd3);
        fifo_full  = 1'b0;
        fifo_level = 5'd0;

        // Health test: A,A,A faults on the third
        send(32'hAAAA_AAAA, 1'b1);
        send(32'hAAAA_AAAA, 1'b1);
        send(32'hAAAA_AAAA, 1'b0);
        check("rep_fault", 32'(fault), 32'd1);
        check("rep_state", 32'(state_out), 32'd5);
        check("rep_enable", 32'(trng_enable), 32'd0);
        check("rep_wc", word_count, 32'd4);
        send(32'h6666_0001, 1'b0);
        check("fault_nodrop", 32'(drop_count), 32'd4);
        fault_clr = 1'b1;
        step();
        fault_clr = 1'b0;
        check("clr_state", 32'(state_out), 32'd0);
        check("clr_fault", 32'(fault), 32'd0);
        check("clr_wc", word_count, 32'd4);

        // Restart, then A,B,A,A must not fault
        step();
        check("re_warm_state", 32'(state_out), 32'd1);
        step(8);
        check("re_disc_state", 32'(state_out), 32'd2);
        send(32'h7777_0001, 1'b0);
        send(32'h7777_0002, 1'b0);
        send(32'hAAAA_AAAA, 1'b1);
        send(32'hBBBB_BBBB, 1'b1);
        send(32'hAAAA_AAAA, 1'b1);
        send(32'hAAAA_AAAA, 1'b1);
        check("abaa_fault", 32'(fault), 32'd0);
        check("abaa_state", 32'(state_out), 32'd3);
        check("abaa_wc", word_count, 32'd8);

        // Abort mid-RUN: the word in the abort cycle is still written
        host_enable = 1'b0;
        send(32'hC0DE_0003, 1'b1);
        check("abort_state", 32'(state_out), 32'd0);
        check("abort_enable", 32'(trng_enable), 32'd0);
        check("abort_wc", word_count, 32'd9);
        check("abort_q", 32'(exp_q.size()), 32'd0);

        // Async reset while paused with drop_count=7
        host_enable = 1'b1;
        step(9);
        send(32'h8888_0001, 1'b0);
        send(32'h8888_0002, 1'b0);
        check("pre_pause_state", 32'(state_out), 32'd3);
        fifo_level = 5'd14;
        step();
        check("pause2_state", 32'(state_out), 32'd4);
        send(32'h9999_0001, 1'b0);
        send(32'h9999_0002, 1'b0);
        send(32'h9999_0003, 1'b0);
        check("pause2_drop", 32'(drop_count), 32'd7);
        #2 rst = 1'b1;
        #1;
        check("arst_state", 32'(state_out), 32'd0);
        check("arst_enable", 32'(trng_enable), 32'd0);
        check("arst_fault", 32'(fault), 32'd0);
        check("arst_wc", word_count, 32'd0);
        check("arst_drop", 32'(drop_count), 32'd0);
        check("arst_wr_en", 32'(wr_en), 32'd0);
        step();
        rst         = 1'b0;
        host_enable = 1'b0;
        fifo_level  = 5'd0;
        step(2);
        check("final_q", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
